// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 5;

  // Hazard FSM: running normally, or waiting on a stalled data-memory access.
  typedef enum logic [0:0] {
    StRun  = 1'b0,
    StWait = 1'b1
  } hazard_state_e;

  // EX operand source selects.
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one EX operand. Purely combinational; x0 never forwarded.
module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned AddrW = REG_ADDR_W_DEF
) (
  input  logic [AddrW-1:0] ex_rs_i,
  input  logic [AddrW-1:0] mem_rd_i,
  input  logic             mem_reg_write_i,
  input  logic [AddrW-1:0] wb_rd_i,
  input  logic             wb_reg_write_i,
  output logic [1:0]       fwd_sel_o
);

  // Youngest producer (EX/MEM) wins over MEM/WB.
  always_comb begin
    fwd_sel_o = FWD_RF;
    if (mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i)) begin
      fwd_sel_o = FWD_EXMEM;
    end else if (wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == ex_rs_i)) begin
      fwd_sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline.
// Optional macro PIPE_HAZARD_PERF_EN adds saturating event counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_MemRead,
  input  logic                  ex_redirect,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_RegWrite,
  input  logic                  mem_access,
  input  logic                  dmem_ready,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_RegWrite,
  output logic                  pc_hold,
  output logic                  if_id_hold,
  output logic                  id_ex_hold,
  output logic                  ex_mem_hold,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  mem_wb_bubble,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  mem_wait
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0]     perf_mem_stall,
  output logic [PERF_W-1:0]     perf_load_use,
  output logic [PERF_W-1:0]     perf_flush
`endif
);

  hazard_state_e state_q, state_d;
  logic          freeze;
  logic          load_use;

  // Memory freeze: a fresh access missing in RUN, or still missing in WAIT.
  always_comb begin
    freeze   = ((state_q == StRun) && mem_access && !dmem_ready) ||
               ((state_q == StWait) && !dmem_ready);
    load_use = ex_MemRead && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  end

  // Next-state logic for the memory-wait FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (mem_access && !dmem_ready) state_d = StWait;
      StWait:  if (dmem_ready) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StRun;
    else       state_q <= state_d;
  end

  // Hold/flush outputs: freeze > redirect > load-use > normal.
  // A redirect during a freeze is not lost: EX is held, so it fires on release.
  always_comb begin
    pc_hold       = 1'b0;
    if_id_hold    = 1'b0;
    id_ex_hold    = 1'b0;
    ex_mem_hold   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (freeze) begin
      pc_hold       = 1'b1;
      if_id_hold    = 1'b1;
      id_ex_hold    = 1'b1;
      ex_mem_hold   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_hold     = 1'b1;
      if_id_hold  = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  // mem_wait is the registered state, so it trails the first stalled cycle.
  always_comb begin
    mem_wait = (state_q == StWait);
  end

  fwd_unit #(
    .AddrW (REG_ADDR_W)
  ) u_fwd_a (
    .ex_rs_i         (ex_rs1),
    .mem_rd_i        (mem_rd),
    .mem_reg_write_i (mem_RegWrite),
    .wb_rd_i         (wb_rd),
    .wb_reg_write_i  (wb_RegWrite),
    .fwd_sel_o       (fwd_a)
  );

  fwd_unit #(
    .AddrW (REG_ADDR_W)
  ) u_fwd_b (
    .ex_rs_i         (ex_rs2),
    .mem_rd_i        (mem_rd),
    .mem_reg_write_i (mem_RegWrite),
    .wb_rd_i         (wb_rd),
    .wb_reg_write_i  (wb_RegWrite),
    .fwd_sel_o       (fwd_b)
  );

`ifdef PIPE_HAZARD_PERF_EN
  logic [PERF_W-1:0] perf_mem_stall_q, perf_mem_stall_d;
  logic [PERF_W-1:0] perf_load_use_q, perf_load_use_d;
  logic [PERF_W-1:0] perf_flush_q, perf_flush_d;
  logic              ev_load_use;
  logic              ev_flush;

  // Count only events that actually took effect after priority resolution.
  always_comb begin
    ev_load_use      = !freeze && !ex_redirect && load_use;
    ev_flush         = !freeze && ex_redirect;
    perf_mem_stall_d = perf_mem_stall_q;
    perf_load_use_d  = perf_load_use_q;
    perf_flush_d     = perf_flush_q;
    if (freeze && (perf_mem_stall_q != '1)) perf_mem_stall_d = perf_mem_stall_q + PERF_W'(1);
    if (ev_load_use && (perf_load_use_q != '1)) perf_load_use_d = perf_load_use_q + PERF_W'(1);
    if (ev_flush && (perf_flush_q != '1)) perf_flush_d = perf_flush_q + PERF_W'(1);
  end

  // Saturating counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_mem_stall_q <= '0;
      perf_load_use_q  <= '0;
      perf_flush_q     <= '0;
    end else begin
      perf_mem_stall_q <= perf_mem_stall_d;
      perf_load_use_q  <= perf_load_use_d;
      perf_flush_q     <= perf_flush_d;
    end
  end

  assign perf_mem_stall = perf_mem_stall_q;
  assign perf_load_use  = perf_load_use_q;
  assign perf_flush     = perf_flush_q;
`else
  // PERF_W only sizes the optional counters; nothing to build without them.
  if (PERF_W == 0) begin : g_no_perf
  end
`endif

endmodule
